adder_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 2-stage `pipelined_adder` instance between `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. It tracks each issued operation's requester ID through the adder latency, then returns the sums in issue order through a credit-protected result FIFO with a valid/ready response port. It sits between the client blocks and the shared adder; the adder instance lives outside this block.

---
 rtl/adder_sched_pkg.sv | 24 ++
 rtl/sched_result_fifo.sv | 75 +++++++
 rtl/adder_rr_scheduler.sv | 150 +++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg
// Shared definitions for the round-robin adder scheduler slice.
//   ADD_LAT        : latency of the shared pipelined_adder (operands in at t,
//                    sum_reg valid during t+ADD_LAT)
//   DEFAULT_WIDTH  : default operand/sum width
//   ID_MAX_W       : widest requester index supported (NREQ up to 8)
//   id_width()     : requester index width, max(1, clog2(n))
//   tag_t          : {valid, id} entry travelling alongside an adder op
package adder_sched_pkg;

  localparam int ADD_LAT       = 2;
  localparam int DEFAULT_WIDTH = 8;
  localparam int ID_MAX_W      = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sched_result_fifo.sv
// sched_result_fifo
// Synchronous result FIFO holding {sum, requester id} pairs.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_sum/id     : write one entry at the tail
//   pop                   : remove the head entry (ignored when empty)
//   head_valid/sum/id     : current head; sum/id read as 0 while empty
//   count                 : number of stored entries (0..DEPTH)
module sched_result_fifo #(
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_sum,
  input  logic [IDW-1:0]         push_id,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_sum,
  output logic [IDW-1:0]         head_id,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] sum_mem [DEPTH];
  logic [IDW-1:0]   id_mem  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == (PW+1)'(DEPTH));
  assign do_pop     = pop && head_valid;
  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle; otherwise the assertion below flags it.
  assign do_push    = push && (!full || do_pop);

  // Head is gated so the response port reads zero while nothing is queued.
  assign head_sum = head_valid ? sum_mem[rd_ptr] : '0;
  assign head_id  = head_valid ? id_mem[rd_ptr]  : '0;

  // Storage needs no reset: every location is written before it is read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      sum_mem[wr_ptr] <= push_sum;
      id_mem[wr_ptr]  <= push_id;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  push_while_full: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push && full && !pop));

endmodule

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Shares one external 2-stage pipelined adder between NREQ requesters.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/ready      : per-requester handshake, at most one ready bit high
//   req_a, req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a, add_b         : operands to the adder (0 when nothing is issued)
//   add_sum              : adder sum_reg, valid ADD_LAT cycles after issue
//   rsp_valid/ready      : response handshake for the result FIFO head
//   rsp_sum, rsp_id      : head sum and the requester it belongs to
//   busy                 : an op is in the adder or a result is queued
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  input  logic [WIDTH-1:0]          add_sum,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic                      busy
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int IFW = $clog2(ADD_LAT + 1);

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_found;
  logic           can_grant;
  logic           handshake;

  tag_t           tag_q [ADD_LAT];
  logic [IFW-1:0] inflight;
  logic [CW-1:0]  fifo_count;
  logic           push;
  logic [IDW-1:0] push_id;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Every issued op holds a slot from grant until its response is popped,
  // so the FIFO can never overflow. rst_n is folded in so req_ready reads
  // zero the moment reset is asserted.
  assign can_grant = rst_n && ((int'(fifo_count) + int'(inflight)) < DEPTH);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_grant && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign handshake = |(req_valid & req_ready);

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (handshake) begin
      add_a = a_arr[grant_idx];
      add_b = b_arr[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (handshake) begin
      last_grant <= grant_idx;
    end
  end

  // Tag pipeline mirrors the adder's latency so the id lines up with
  // add_sum in the cycle the sum becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0].valid <= handshake;
      tag_q[0].id    <= handshake ? ID_MAX_W'(grant_idx) : '0;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ADD_LAT; i++) begin
      inflight = inflight + IFW'(tag_q[i].valid);
    end
  end

  assign push    = tag_q[ADD_LAT-1].valid;
  assign push_id = IDW'(tag_q[ADD_LAT-1].id);

  sched_result_fifo #(
    .WIDTH (WIDTH),
    .IDW   (IDW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_sum   (add_sum),
    .push_id    (push_id),
    .pop        (rsp_ready),
    .head_valid (rsp_valid),
    .head_sum   (rsp_sum),
    .head_id    (rsp_id),
    .count      (fifo_count)
  );

  assign busy = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler
// Self-checking bench for adder_rr_scheduler. The shared adder is modelled
// here as a two-register pipeline. The reference model keeps a queue of
// accepted operations (requester, expected sum, issue cycle): a grant is
// expected when fewer than DEPTH ops are outstanding, the head response is
// expected three cycles after its issue, and busy means the queue is non-empty.
module tb_adder_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_sum;
  logic [WIDTH-1:0]      adder_stage;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic [1:0]            rsp_id;
  logic                  busy;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] sum;
    int               issue;
  } op_t;

  op_t model_q[$];
  int  last_grant;
  int  cycle;
  int  checks   = 0;
  int  failures = 0;

  adder_rr_scheduler #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared pipelined_adder: sum_reg two cycles after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_stage <= '0;
      add_sum     <= '0;
    end else begin
      adder_stage <= add_a + add_b;
      add_sum     <= adder_stage;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model,
  // then advances the model past this cycle's handshakes.
  task automatic applyStimulus(input logic [NREQ-1:0] v,
                               input logic [NREQ*WIDTH-1:0] a,
                               input logic [NREQ*WIDTH-1:0] b,
                               input logic rr);
    logic [NREQ-1:0]  exp_ready;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic             exp_rvalid;
    int               gid;
    int               idx;
    op_t              op;
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    gid = -1;
    if (model_q.size() < DEPTH) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (last_grant + k) % NREQ;
        if (gid < 0 && ((v >> idx) & NREQ'(1)) != '0) gid = idx;
      end
    end
    exp_ready = '0;
    exp_a     = '0;
    exp_b     = '0;
    if (gid >= 0) begin
      exp_ready = NREQ'(1) << gid;
      exp_a     = WIDTH'(a >> (gid * WIDTH));
      exp_b     = WIDTH'(b >> (gid * WIDTH));
    end
    exp_rvalid = (model_q.size() != 0) && (model_q[0].issue + 3 <= cycle);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("add_a", 32'(add_a), 32'(exp_a));
    checkOutput("add_b", 32'(add_b), 32'(exp_b));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rvalid));
    checkOutput("busy", 32'(busy), 32'(model_q.size() != 0));
    if (exp_rvalid) begin
      checkOutput("rsp_sum", 32'(rsp_sum), 32'(model_q[0].sum));
      checkOutput("rsp_id", 32'(rsp_id), 32'(model_q[0].id));
      if (rr) void'(model_q.pop_front());
    end
    if (gid >= 0) begin
      op.id    = gid;
      op.sum   = exp_a + exp_b;
      op.issue = cycle;
      model_q.push_back(op);
      last_grant = gid;
    end
    cycle++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NREQ*WIDTH-1:0] pa;
    logic [NREQ*WIDTH-1:0] pb;
    int                    hs;

    clk        = 1'b0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    last_grant = NREQ - 1;
    cycle      = 0;

    #2;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_add_a", 32'(add_a), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single op");
    repeat (4) applyStimulus('0, '0, '0, 1'b0);
    pa = '0; pb = '0;
    pa[7:0] = 8'h12; pb[7:0] = 8'h34;
    applyStimulus(4'b0001, pa, pb, 1'b0);
    repeat (2) applyStimulus('0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("single_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_sum", 32'(rsp_sum), 32'h46);
    checkOutput("single_id", 32'(rsp_id), 32'd0);

    $display("[TB] wrap");
    pa = '0; pb = '0;
    pa[31:24] = 8'hF0; pb[31:24] = 8'h25;
    applyStimulus(4'b1000, pa, pb, 1'b0);
    repeat (2) applyStimulus('0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("wrap_sum", 32'(rsp_sum), 32'h15);
    checkOutput("wrap_id", 32'(rsp_id), 32'd3);
    applyStimulus('0, '0, '0, 1'b1);

    $display("[TB] round robin stream");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, $urandom, $urandom, 1'b1);
      checkOutput("rr_grant", 32'(req_ready), 32'(NREQ'(1) << (i % NREQ)));
      if (i >= 3) checkOutput("stream_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    repeat (6) applyStimulus('0, '0, '0, 1'b1);

    $display("[TB] backpressure");
    hs = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b1111, $urandom, $urandom, 1'b0);
      if ((req_valid & req_ready) != '0) hs++;
    end
    checkOutput("bp_handshakes", 32'(hs), 32'(DEPTH));
    checkOutput("bp_stalled", 32'(req_ready), 32'd0);
    applyStimulus(4'b1111, $urandom, $urandom, 1'b1);
    checkOutput("bp_no_grant_on_first_pop", 32'(req_ready), 32'd0);
    applyStimulus(4'b1111, $urandom, $urandom, 1'b1);
    checkOutput("bp_grant_resumes", 32'(req_ready != '0), 32'd1);
    repeat (10) applyStimulus('0, '0, '0, 1'b1);

    $display("[TB] reset mid-operation");
    repeat (4) applyStimulus(4'b1111, $urandom, $urandom, 1'b0);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("midreset_add_a", 32'(add_a), 32'd0);
    checkOutput("midreset_add_b", 32'(add_b), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_rsp_sum", 32'(rsp_sum), 32'd0);
    checkOutput("midreset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    model_q.delete();
    last_grant = NREQ - 1;
    req_valid  = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, $urandom, $urandom, 1'b1);
    checkOutput("post_reset_first_grant", 32'(req_ready), 32'd1);
    repeat (6) applyStimulus('0, '0, '0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(NREQ'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0));
    end
    repeat (12) applyStimulus('0, '0, '0, 1'b1);
    checkOutput("final_busy", 32'(busy), 32'd0);
    checkOutput("final_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
